seq_divider: RTL
================

SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter DIVIDEND_W, default 8: dividend and quotient width.
REQ-002 SHALL have parameter DIVISOR_W, default 4: divisor and remainder width.
REQ-003 SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: request a division; sampled only in IDLE.
REQ-006 SHALL have port dividend, input, DIVIDEND_W bits: unsigned numerator; latched on the accepted start.
REQ-007 SHALL have port divisor, input, DIVISOR_W bits: unsigned denominator; latched on the accepted start.
REQ-008 SHALL have port busy, output, 1 bit: high while in RUN.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse, high while in DONE.
REQ-010 SHALL have port quotient, output, DIVIDEND_W bits: registered result.
REQ-011 SHALL have port remainder, output, DIVISOR_W bits: registered result.

Function
REQ-012 SHALL implement FSM states IDLE, RUN and DONE.
REQ-013 SHALL make these FSM transitions:
- IDLE to RUN on start=1
- RUN to DONE after DIVIDEND_W iterations
- DONE to IDLE unconditionally
REQ-014 On the accepted start edge (edge 0), SHALL latch both operands, clear the partial remainder (DIVISOR_W+1 bits) and clear the iteration counter.
REQ-015 SHALL perform one restoring iteration per RUN cycle, MSB first:
- R = {R[DIVISOR_W-1:0], next dividend bit}
- if R >= divisor: subtract the divisor and set the quotient bit to 1; otherwise set the quotient bit to 0
REQ-016 SHALL enter DONE at edge DIVIDEND_W (edge 8 by default); done and updated quotient/remainder SHALL be visible in the cycle following that edge.
REQ-017 SHALL hold quotient and remainder stable until the next entry to DONE.
REQ-018 SHALL ignore start while in RUN or DONE; start is not queued.
REQ-019 Earliest back-to-back acceptance SHALL be two edges after the DONE edge.
REQ-020 Operand input changes after acceptance SHALL NOT affect the result in progress.
REQ-021 For divisor 0, the iteration itself SHALL yield quotient all-ones and remainder = dividend[DIVISOR_W-1:0].
REQ-022 All arithmetic SHALL be unsigned; no output overflow is possible.

Reset
REQ-023 reset_n=0 SHALL immediately force the following, regardless of clock:
- state = IDLE
- busy = 0, done = 0
- quotient = 0, remainder = 0
- counter and working registers = 0
REQ-024 Reset asserted during RUN or DONE SHALL abort the division; no done pulse is produced for the aborted operation.
REQ-025 The first start SHALL be accepted on the first rising edge after reset_n deasserts.

Configuration
REQ-026 Macro SEQ_DIVIDER_DIV0_EN defined SHALL add output port div0 (1 bit). With the macro:
- a zero divisor at start goes IDLE to DONE directly, skipping RUN
- done occurs in the cycle after the start edge
- quotient = all-ones, remainder = dividend[DIVISOR_W-1:0], div0 = 1
- div0 is registered, changes only on entry to DONE, and resets to 0
REQ-027 Macro SEQ_DIVIDER_DIV0_EN undefined SHALL omit div0 port and logic; a zero divisor runs the full DIVIDEND_W iterations per REQ-021.

Structure
REQ-028 Shared package div_pkg SHALL hold:
- the FSM state typedef (IDLE/RUN/DONE)
- default width constants
- the counter width derived from DIVIDEND_W
REQ-029 Sub-module div_step SHALL contain the combinational shift/compare/subtract iteration, instantiated once in seq_divider.

Verification
REQ-030 Nominal: dividend=200, divisor=7, start 1 cycle -> busy 8 cycles, done pulse, quotient=28, remainder=4.
REQ-031 Bounds:
- dividend=255, divisor=1 -> quotient=255, remainder=0
- dividend=5, divisor=9 -> quotient=0, remainder=5
REQ-032 Zero divisor, dividend=0xA7:
- without macro -> done after 8 RUN cycles, quotient=0xFF, remainder=7
- with macro -> done one cycle after start, div0=1, same values
REQ-033 Start held high through RUN, with operands changed mid-run -> single done, result from the originally latched operands, next acceptance only after return to IDLE.
REQ-034 reset_n pulsed low at RUN iteration 4 -> all outputs 0 immediately, no done pulse; next start 100/3 -> quotient=33, remainder=1.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: FSM state encoding,
// default operand widths and the iteration-counter width helper.
package div_pkg;

    localparam int DEF_DIVIDEND_W = 8;
    localparam int DEF_DIVISOR_W  = 4;

    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t RUN  = 2'd1;
    localparam state_t DONE = 2'd2;

    // Counter only has to reach DIVIDEND_W-1.
    function automatic int cnt_w(input int dividend_w);
        return (dividend_w < 2) ? 1 : $clog2(dividend_w);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, then conditionally subtract the divisor.
module div_step #(
    parameter int DIVISOR_W = 4
) (
    input  logic [DIVISOR_W:0]   rem_in,
    input  logic                 bit_in,
    input  logic [DIVISOR_W-1:0] divisor,
    output logic [DIVISOR_W:0]   rem_out,
    output logic                 q_bit
);

    logic [DIVISOR_W:0] shifted;
    logic               unused_msb;

    // The top bit is always shifted out; it only exists to hold the trial value.
    assign unused_msb = rem_in[DIVISOR_W];
    assign shifted    = {rem_in[DIVISOR_W-1:0], bit_in};
    assign q_bit      = (shifted >= {1'b0, divisor});
    assign rem_out    = q_bit ? (shifted - {1'b0, divisor}) : shifted;

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider, one quotient bit per RUN cycle.
// Optional macro SEQ_DIVIDER_DIV0_EN adds a div0 flag and a zero-divisor fast path.
module seq_divider
    import div_pkg::*;
#(
    parameter int DIVIDEND_W = DEF_DIVIDEND_W,
    parameter int DIVISOR_W  = DEF_DIVISOR_W
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder
`ifdef SEQ_DIVIDER_DIV0_EN
    ,
    output logic                  div0
`endif
);

    localparam int CNT_W = cnt_w(DIVIDEND_W);

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic [DIVIDEND_W-1:0] work;
    logic [DIVISOR_W-1:0]  dsr;
    logic [DIVISOR_W:0]    rem;
    logic [DIVISOR_W:0]    rem_nxt;
    logic                  q_bit;
    logic                  last;

    // work shifts dividend bits out of the MSB while quotient bits enter at the LSB.
    div_step #(.DIVISOR_W(DIVISOR_W)) u_step (
        .rem_in  (rem),
        .bit_in  (work[DIVIDEND_W-1]),
        .divisor (dsr),
        .rem_out (rem_nxt),
        .q_bit   (q_bit)
    );

    assign last = (cnt == CNT_W'(DIVIDEND_W - 1));
    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            work      <= '0;
            dsr       <= '0;
            rem       <= '0;
            quotient  <= '0;
            remainder <= '0;
`ifdef SEQ_DIVIDER_DIV0_EN
            div0      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (start) begin
                    dsr  <= divisor;
                    work <= dividend;
                    rem  <= '0;
                    cnt  <= '0;
`ifdef SEQ_DIVIDER_DIV0_EN
                    if (divisor == '0) begin
                        state     <= DONE;
                        quotient  <= '1;
                        remainder <= dividend[DIVISOR_W-1:0];
                        div0      <= 1'b1;
                    end else begin
                        state <= RUN;
                    end
`else
                    state <= RUN;
`endif
                end
                RUN: begin
                    rem  <= rem_nxt;
                    work <= {work[DIVIDEND_W-2:0], q_bit};
                    cnt  <= cnt + CNT_W'(1);
                    if (last) begin
                        state     <= DONE;
                        quotient  <= {work[DIVIDEND_W-2:0], q_bit};
                        remainder <= rem_nxt[DIVISOR_W-1:0];
`ifdef SEQ_DIVIDER_DIV0_EN
                        div0      <= 1'b0;
`endif
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
